// File: rtl/serial_addsub_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_addsub_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle between a requester and serial_addsub.
interface serial_addsub_if
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (output start, sub, a, b, input busy, done, result, cout);
  modport slave  (input start, sub, a, b, output busy, done, result, cout);
endinterface

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  logic h1, c1, c2;

  assign h1 = x ^ y;
  assign c1 = x & y;
  assign s  = h1 ^ cin;
  assign c2 = h1 & cin;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first through a single full-adder cell.
// Subtraction is a + ~b + 1, so the carry register is seeded with sub.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic             sub_r;
  logic [CW-1:0]    cnt;
  logic             s, co;
  logic             take;
  logic             last;

  fa_cell u_fa (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .cin (carry),
    .s   (s),
    .co  (co)
  );

  assign take = bus.start && (state == IDLE || state == DONE);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      carry      <= 1'b0;
      sub_r      <= 1'b0;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (take) begin
        a_sh     <= bus.a;
        b_sh     <= bus.sub ? ~bus.b : bus.b;
        carry    <= bus.sub;
        sub_r    <= bus.sub;
        cnt      <= '0;
        bus.busy <= 1'b1;
        state    <= RUN;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          RUN: begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {s, r_sh[WIDTH-1:1]};
            carry <= co;
            cnt   <= cnt + CW'(1);
            if (last) begin
              // Visible outputs only change here, so they hold between results.
              bus.result <= {s, r_sh[WIDTH-1:1]};
              bus.cout   <= co ^ sub_r;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              state      <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
